// File: rtl/stream_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : stream_upsizer
// Brief    : Packs RATIO WIDTH-bit valid/ready beats into one registered
//            RATIO*WIDTH-bit word. Define STREAM_UPSIZER_LAST_EN to enable
//            early close with last_a and the keep_b/last_b sideband outputs.
// Revision : 1.0 - initial release
// ============================================================================
module stream_upsizer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_a,
  input  logic                     vld_a,
  output logic                     rdy_a,
`ifdef STREAM_UPSIZER_LAST_EN
  input  logic                     last_a,
  output logic [RATIO-1:0]         keep_b,
  output logic                     last_b,
`endif
  output logic [RATIO*WIDTH-1:0]   data_b,
  output logic                     vld_b,
  input  logic                     rdy_b
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(RATIO - 1);

  logic [RATIO-2:0][WIDTH-1:0] collect_q, collect_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [RATIO*WIDTH-1:0]      data_q, data_d;
  logic                        vld_q, vld_d;
  logic [RATIO*WIDTH-1:0]      pack_w;
  logic                        close_w;
  logic                        last_in_w;
  logic                        gnt_a_w;
  logic                        gnt_b_w;

`ifdef STREAM_UPSIZER_LAST_EN
  logic [RATIO-1:0]            keep_q, keep_d, keep_w;
  logic                        last_q, last_d;
  assign last_in_w = last_a;
`else
  assign last_in_w = 1'b0;
`endif

  // Packed word as it would look if the current beat closed it: stored lanes
  // below cnt, the live beat in lane cnt, zeros above.
  generate
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
      if (k < RATIO - 1) begin : g_col
        assign pack_w[k*WIDTH +: WIDTH] = (CW'(k) < cnt_q)  ? collect_q[k] :
                                          (CW'(k) == cnt_q) ? data_a       : '0;
      end else begin : g_top
        assign pack_w[k*WIDTH +: WIDTH] = (CW'(k) == cnt_q) ? data_a : '0;
      end
`ifdef STREAM_UPSIZER_LAST_EN
      assign keep_w[k] = (CW'(k) <= cnt_q);
`endif
    end
  endgenerate

  assign close_w = (cnt_q == C_CNT_MAX) || last_in_w;
  // Only a closing beat needs room in the output stage.
  assign rdy_a   = close_w ? (!vld_q || rdy_b) : 1'b1;
  assign gnt_a_w = vld_a && rdy_a;
  assign gnt_b_w = vld_q && rdy_b;

  always_comb begin
    collect_d = collect_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    vld_d     = vld_q;
`ifdef STREAM_UPSIZER_LAST_EN
    keep_d    = keep_q;
    last_d    = last_q;
`endif
    if (gnt_b_w) begin
      vld_d = 1'b0;
    end
    if (gnt_a_w) begin
      if (close_w) begin
        data_d    = pack_w;
        vld_d     = 1'b1;
        cnt_d     = '0;
        collect_d = '0;
`ifdef STREAM_UPSIZER_LAST_EN
        keep_d    = keep_w;
        last_d    = last_a;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CW'(k) == cnt_q) begin
            collect_d[k] = data_a;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      collect_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
      keep_q    <= '0;
      last_q    <= 1'b0;
`endif
    end else begin
      collect_q <= collect_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
`ifdef STREAM_UPSIZER_LAST_EN
      keep_q    <= keep_d;
      last_q    <= last_d;
`endif
    end
  end

  assign data_b = data_q;
  assign vld_b  = vld_q;
`ifdef STREAM_UPSIZER_LAST_EN
  assign keep_b = keep_q;
  assign last_b = last_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_upsizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_upsizer
// Brief    : Scoreboard bench for stream_upsizer (WIDTH=32, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_upsizer;

  localparam int WIDTH = 32;
  localparam int RATIO = 4;
  localparam int WW    = WIDTH * RATIO;

  typedef struct packed {
    logic [WW-1:0]    data;
    logic [RATIO-1:0] keep;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_a = '0;
  logic             vld_a = 1'b0;
  logic             rdy_a;
  logic [WW-1:0]    data_b;
  logic             vld_b;
  logic             rdy_b = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
  logic             last_a = 1'b0;
  logic [RATIO-1:0] keep_b;
  logic             last_b;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   vld_cnt  = 0;
  int   stalls   = 0;
  exp_t sb[$];

  stream_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_a (data_a),
    .vld_a  (vld_a),
    .rdy_a  (rdy_a),
`ifdef STREAM_UPSIZER_LAST_EN
    .last_a (last_a),
    .keep_b (keep_b),
    .last_b (last_b),
`endif
    .data_b (data_b),
    .vld_b  (vld_b),
    .rdy_b  (rdy_b)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard on every output handshake and checks
  // that a stalled word stays put.
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (vld_b) vld_cnt++;
      if (prev_stall) begin
        check("stall_vld_b", WW'(vld_b), WW'(1));
        check("stall_data_b", data_b, prev_data);
      end
      if (vld_b && rdy_b) begin
        if (sb.size() == 0) begin
          check("unexpected_word", data_b, '0);
          if (data_b == '0) check("unexpected_word_vld", WW'(vld_b), WW'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", data_b, e.data);
`ifdef STREAM_UPSIZER_LAST_EN
          check("word_keep", WW'(keep_b), WW'(e.keep));
          check("word_last", WW'(last_b), WW'(e.last));
`endif
        end
      end
      prev_stall = vld_b && !rdy_b;
      prev_data  = data_b;
    end
  end

  function automatic void push_word(logic [WW-1:0] d);
    exp_t e;
    e.data = d;
    e.keep = '1;
    e.last = 1'b0;
    sb.push_back(e);
  endfunction

  task automatic wait_accept();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (rdy_a) break;
      stalls++;
      t++;
      if (t > 50) begin
        check("accept_timeout", WW'(rdy_a), WW'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(logic [WIDTH-1:0] d);
    data_a = d;
    vld_a  = 1'b1;
`ifdef STREAM_UPSIZER_LAST_EN
    last_a = 1'b0;
`endif
    wait_accept();
  endtask

  task automatic idle(int n);
    vld_a = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
    last_a = 1'b0;
`endif
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld_a = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    int t;
    do_reset();
    @(negedge clk);
    check("reset_vld_b", WW'(vld_b), WW'(0));
    check("reset_data_b", data_b, '0);
    check("reset_rdy_a", WW'(rdy_a), WW'(1));
`ifdef STREAM_UPSIZER_LAST_EN
    check("reset_keep_b", WW'(keep_b), WW'(0));
    check("reset_last_b", WW'(last_b), WW'(0));
`endif
    @(posedge clk);
    #1;

    // One full word, consumer ready
    rdy_b  = 1'b1;
    stalls = 0;
    push_word(128'h00000004_00000003_00000002_00000001);
    for (int i = 1; i <= 4; i++) send_beat(WIDTH'(i));
    check("t1_latency_vld_b", WW'(vld_b), WW'(1));
    check("t1_data_b", data_b, 128'h00000004_00000003_00000002_00000001);
    check("t1_no_stall", WW'(stalls), WW'(0));
    idle(3);

    // Eight back-to-back beats
    vld_cnt = 0;
    stalls  = 0;
    push_word(128'h00000014_00000013_00000012_00000011);
    push_word(128'h00000018_00000017_00000016_00000015);
    for (int i = 0; i < 8; i++) send_beat(WIDTH'(32'h11 + i));
    idle(3);
    check("t2_no_stall", WW'(stalls), WW'(0));
    check("t2_vld_cycles", WW'(vld_cnt), WW'(2));

    // Consumer stalled: beats 5-7 accepted, beat 8 waits for drain
    rdy_b = 1'b0;
    push_word(128'h00000024_00000023_00000022_00000021);
    push_word(128'h00000028_00000027_00000026_00000025);
    for (int i = 0; i < 7; i++) send_beat(WIDTH'(32'h21 + i));
    data_a = 32'h28;
    vld_a  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_close_stalls", WW'(rdy_a), WW'(0));
      @(posedge clk);
      #1;
    end
    rdy_b = 1'b1;
    @(negedge clk);
    check("t3_close_ready", WW'(rdy_a), WW'(1));
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    check("t3_load_vld_b", WW'(vld_b), WW'(1));
    check("t3_load_data_b", data_b, 128'h00000028_00000027_00000026_00000025);
    idle(3);

`ifdef STREAM_UPSIZER_LAST_EN
    begin
      exp_t e;
      e.data = 128'h00000000_00000000_0000000B_0000000A;
      e.keep = 4'b0011;
      e.last = 1'b1;
      sb.push_back(e);
      e.data = 128'h00000000_00000000_00000000_00000005;
      e.keep = 4'b0001;
      e.last = 1'b1;
      sb.push_back(e);
    end
    send_beat(32'hA);
    data_a = 32'hB;
    vld_a  = 1'b1;
    last_a = 1'b1;
    wait_accept();
    check("t4_keep_b", WW'(keep_b), WW'(4'b0011));
    data_a = 32'h5;
    last_a = 1'b1;
    wait_accept();
    check("t5_data_b", data_b, 128'h5);
    check("t5_keep_b", WW'(keep_b), WW'(4'b0001));
    idle(3);
`endif

    // Reset mid-collection, then a clean word
    send_beat(32'hDEAD);
    send_beat(32'hBEEF);
    do_reset();
    @(negedge clk);
    check("t6_rst_vld_b", WW'(vld_b), WW'(0));
    check("t6_rst_rdy_a", WW'(rdy_a), WW'(1));
    @(posedge clk);
    #1;
    push_word(128'h00000034_00000033_00000032_00000031);
    for (int i = 0; i < 4; i++) send_beat(WIDTH'(32'h31 + i));
    check("t6_clean_data_b", data_b, 128'h00000034_00000033_00000032_00000031);
    idle(3);

    // Reset drops a pending word
    rdy_b = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(WIDTH'(32'h41 + i));
    idle(1);
    check("t7_pending_vld_b", WW'(vld_b), WW'(1));
    do_reset();
    check("t7_dropped_vld_b", WW'(vld_b), WW'(0));
    rdy_b = 1'b1;
    idle(3);

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_empty", WW'(sb.size()), WW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_upsizer.md
# stream_upsizer

Valid/ready width converter sitting directly downstream of the single-entry pipeline register stage. It packs RATIO consecutive WIDTH-bit beats into one RATIO*WIDTH-bit word and presents the packed word through a registered output holding stage. Full input throughput is kept as long as the consumer drains one wide word every RATIO cycles. Optionally, a partial word can be flushed early with a last marker.

## Interface
- WIDTH, 32: input beat width in bits.
- RATIO, 4: beats per output word; integer ≥ 2.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_a  input  WIDTH  input beat.
- vld_a  input  1  input beat valid.
- rdy_a  output  1  block accepts beat when vld_a && rdy_a.
- last_a  input  1  final beat of packet (STREAM_UPSIZER_LAST_EN only).
- data_b  output  RATIO*WIDTH  packed word; beat k in bits [k*WIDTH +: WIDTH].
- vld_b  output  1  packed word valid.
- rdy_b  input  1  consumer accepts when vld_b && rdy_b.
- keep_b  output  RATIO  lane k holds a real beat (STREAM_UPSIZER_LAST_EN only).
- last_b  output  1  word ends a packet (STREAM_UPSIZER_LAST_EN only).

## Operation
- Internal state: collect register (RATIO-1 lanes of WIDTH), beat counter cnt of width $clog2(RATIO), range 0..RATIO-1. Output stage: data_b/vld_b/keep_b/last_b registers.
- Accept (gnt_a = vld_a && rdy_a) with cnt < RATIO-1 and no closing condition: write data_a into lane cnt, cnt <= cnt+1.
- Closing beat: cnt == RATIO-1, or last_a=1 when LAST_EN. On gnt_a: data_b <= collect lanes 0..cnt-1 with data_a in lane cnt; lanes above cnt are zero. vld_b <= 1, cnt <= 0, collect cleared.
- rdy_a = 1 if the beat does not close; if it closes, rdy_a = !vld_b || rdy_b. rdy_a may depend on vld_a/last_a; vld_b never depends on rdy_b.
- Output drain: gnt_b = vld_b && rdy_b. If gnt_b and no closing gnt_a the same cycle, vld_b <= 0; data_b holds last value. If both, new word loads, vld_b stays 1.
- While vld_b && !rdy_b: data_b, keep_b, last_b are stable.
- Partial beats never leave without a closing beat.

## Timing
- Reset (rst=1 at clk edge): vld_b=0, data_b=0, keep_b=0, last_b=0, cnt=0, collect=0. After reset rdy_a=1.
- Reset mid-collection discards partial beats; reset with vld_b=1 drops the pending word.
- Latency: closing beat accepted at edge N -> vld_b=1 after edge N, no bubbles.
- Throughput: one beat per cycle with rdy_b high; with rdy_b low, non-closing beats still accepted (up to RATIO-1), closing beat stalls until vld_b clear or draining.
- Simultaneous close + drain: both occur in the same cycle, no stall.

## Configuration
- STREAM_UPSIZER_LAST_EN defined: last_a, keep_b, last_b exist. last_a closes the word early; keep_b = lanes 0..cnt set ({RATIO{1}} for full word); last_b = last_a of closing beat. keep_b/last_b reset to 0.
- Not defined: ports absent; only cnt == RATIO-1 closes a word; output always full.

## Test plan
- Reset then stream 0x1,0x2,0x3,0x4 with rdy_b=1 (WIDTH=32, RATIO=4) -> vld_b one cycle after 4th beat, data_b=0x00000004_00000003_00000002_00000001, rdy_a held 1.
- Stream 8 back-to-back beats with rdy_b=1 -> two words, no rdy_a deassert, vld_b high exactly 2 cycles.
- rdy_b=0, stream 8 beats -> first word holds; beats 5-7 accepted, beat 8 stalls (rdy_a=0) until rdy_b=1, then second word loads in same cycle as drain.
- LAST_EN: beats 0xA,0xB with last_a on 0xB -> data_b=0x...0000000B_0000000A, keep_b=4'b0011, last_b=1; next packet starts at lane 0.
- LAST_EN: single beat 0x5 with last_a -> keep_b=4'b0001, upper lanes zero.
- Assert rst after 2 beats collected -> vld_b=0, next 4 beats form a clean word with no stale data.
